delayline_ctrl: RTL and testbench

//  Sequencer for the 8-tap x 9-bit ping/pong delay line. Accepts a sample

---
 rtl/dlyctrl_pkg.sv | 23 ++
 rtl/dlyctrl_fhs.sv | 29 ++
 rtl/delayline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_delayline_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlyctrl_pkg.sv
// Shared definitions for the delay-line sequencer: default geometry,
// the sequencer state encoding, the frame counter width and a small
// helper used to decide whether the pong buffer may be overwritten.
package dlyctrl_pkg;

    localparam int DLY_TAPS    = 8;   // samples per frame
    localparam int DLY_DW      = 9;   // sample width
    localparam int DLY_CW      = 4;   // slot index width, 2**CW > TAPS
    localparam int FRAME_CNT_W = 16;  // optional frame counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        SWAP = 2'd3
    } state_t;

    // Pong may take a new frame when it is empty or being drained right now.
    function automatic logic pong_is_free(input logic fvalid, input logic fready);
        return (~fvalid) | fready;
    endfunction

endpackage

// File: rtl/dlyctrl_fhs.sv
// Frame handshake register. f_valid rises the cycle after the swap pulse
// and falls when the downstream consumer takes the frame. A swap landing
// in the same cycle as a consume wins, because pong then holds a new frame.
module dlyctrl_fhs
    import dlyctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_swap,
    input  logic i_f_ready,
    output logic o_f_valid,
    output logic o_pong_free
);

    logic r_f_valid;

    // Frame-valid flag: set by the swap, cleared by a downstream consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_valid <= 1'b0;
        end else begin
            r_f_valid <= i_swap | (r_f_valid & ~i_f_ready);
        end
    end

    assign o_f_valid   = r_f_valid;
    assign o_pong_free = pong_is_free(r_f_valid, i_f_ready);

endmodule

// File: rtl/delayline_ctrl.sv
// Sequencer for the ping/pong delay line. Accepts samples over a
// valid/ready handshake, writes them into ping slots 0..TAPS-1, pulses the
// ping->pong swap once a frame is complete and pong is free, and presents
// the completed frame downstream through the frame handshake register.
// Optional feature macro: DLYCTRL_FRAME_CNT_EN adds a 16-bit frame counter
// output (frame_cnt) that steps on every swap pulse.
module delayline_ctrl
    import dlyctrl_pkg::*;
#(
    parameter int TAPS = DLY_TAPS,
    parameter int DW   = DLY_DW,
    parameter int CW   = DLY_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          dl_load,
    output logic [CW-1:0] dl_count,
    output logic [DW-1:0] dl_data,
    output logic          dl_swap,
    output logic          f_valid,
    input  logic          f_ready,
    output logic          busy
`ifdef DLYCTRL_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam logic [CW-1:0] LAST_SLOT = CW'(TAPS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_slot;
    logic [CW-1:0] w_slot_nxt;
    logic          w_ready;
    logic          w_accept;
    logic          w_swap_issue;
    logic          w_pong_free;
    logic          r_load;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_data;
    logic          r_swap;

    // Next-state, slot advance and handshake decode; every transition is
    // gated by en so that en=0 freezes the sequencer in place.
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_swap_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                w_ready  = en;
                w_accept = en & s_valid;
                if (w_accept) begin
                    if (r_slot == LAST_SLOT) begin
                        // Slot stays at TAPS-1; it is cleared when the swap issues.
                        if (w_pong_free) begin
                            w_state_nxt = SWAP;
                        end else begin
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end else begin
                    w_state_nxt = FILL;
                end
            end
            HOLD: begin
                if (en && w_pong_free) begin
                    w_state_nxt = SWAP;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            SWAP: begin
                if (en) begin
                    w_swap_issue = 1'b1;
                    w_slot_nxt   = '0;
                    w_state_nxt  = FILL;
                end else begin
                    w_state_nxt = SWAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_slot_nxt  = '0;
            end
        endcase
    end

    // State and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Registered delay-line strobes: load one cycle after accept, swap pulse
    // one cycle after the SWAP state is entered with en high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load  <= 1'b0;
            r_count <= '0;
            r_data  <= '0;
            r_swap  <= 1'b0;
        end else begin
            r_load <= w_accept;
            r_swap <= w_swap_issue;
            if (w_accept) begin
                r_count <= r_slot;
                r_data  <= s_data;
            end else begin
                r_count <= r_count;
                r_data  <= r_data;
            end
        end
    end

    dlyctrl_fhs u_fhs (
        .clk         (clk),
        .rst         (rst),
        .i_swap      (r_swap),
        .i_f_ready   (f_ready),
        .o_f_valid   (f_valid),
        .o_pong_free (w_pong_free)
    );

`ifdef DLYCTRL_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    // Frame counter: steps together with the swap pulse, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_swap_issue) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign s_ready  = w_ready;
    assign dl_load  = r_load;
    assign dl_count = r_count;
    assign dl_data  = r_data;
    assign dl_swap  = r_swap;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_delayline_ctrl.sv
// Self-checking bench for delayline_ctrl. A reference model built from
// the frame rules (sample count per frame, pong occupancy, swap latency)
// predicts every strobe; accepted samples are queued and checked when the
// DUT presents the matching dl_load.
module tb_delayline_ctrl;
    import dlyctrl_pkg::*;

    localparam int TAPS = 8;
    localparam int DW   = 9;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst, en, s_valid, f_ready;
    logic [DW-1:0] s_data;
    logic          s_ready, dl_load, dl_swap, f_valid, busy;
    logic [CW-1:0] dl_count;
    logic [DW-1:0] dl_data;
`ifdef DLYCTRL_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    delayline_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .dl_load  (dl_load),
        .dl_count (dl_count),
        .dl_data  (dl_data),
        .dl_swap  (dl_swap),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .busy     (busy)
`ifdef DLYCTRL_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            slot;
        logic [DW-1:0] data;
    } load_t;
    load_t exp_q[$];

    // Reference model state: what the frame rules say is in flight.
    bit          mon_on   = 1'b0;
    bit          m_active = 1'b0;  // left IDLE since last reset
    bit          m_load   = 1'b0;  // a load is due this cycle
    bit          m_swap   = 1'b0;  // a swap pulse is due this cycle
    bit          m_fv     = 1'b0;  // pong holds an unconsumed frame
    bit          m_wait   = 1'b0;  // frame complete, pong still occupied
    bit          m_go     = 1'b0;  // frame complete, swap may issue when enabled
    int          m_filled = 0;     // samples accepted into current frame
    int          m_loads  = 0;     // loads observed since last swap
    logic [15:0] m_frames = 16'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare DUT outputs with the model, then advance the model.
    always @(negedge clk) begin
        if (mon_on) begin
            bit          exp_sr, acc, pf, n_fv, n_swap, n_go, n_wait;
            int          n_filled;
            load_t       it;
            exp_sr = m_active && en && !m_wait && !m_go && (m_filled < TAPS);
            chk("f_valid", f_valid, m_fv);
            chk("dl_load", dl_load, m_load);
            chk("dl_swap", dl_swap, m_swap);
            chk("s_ready", s_ready, exp_sr);
            chk("busy", busy, m_active);
`ifdef DLYCTRL_FRAME_CNT_EN
            chk("frame_cnt", frame_cnt, m_frames);
`endif
            if (dl_load && m_load) begin
                m_loads++;
                if (exp_q.size() == 0) begin
                    chk("load_queue_empty", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("dl_count", dl_count, it.slot);
                    chk("dl_data", dl_data, it.data);
                end
            end
            if (dl_swap) begin
                chk("loads_per_frame", m_loads, TAPS);
                m_loads = 0;
            end
            if (rst) begin
                m_active = 1'b0; m_load = 1'b0; m_swap = 1'b0; m_fv = 1'b0;
                m_wait = 1'b0; m_go = 1'b0; m_filled = 0; m_loads = 0;
                m_frames = 16'd0;
                exp_q.delete();
            end else begin
                acc      = s_valid && exp_sr;
                pf       = !m_fv || f_ready;
                n_fv     = m_swap || (m_fv && !f_ready);
                n_swap   = 1'b0;
                n_go     = m_go;
                n_wait   = m_wait;
                n_filled = m_filled;
                if (m_go && en) begin
                    n_swap   = 1'b1;
                    n_go     = 1'b0;
                    n_filled = 0;
                    m_frames = m_frames + 16'd1;
                end
                if (m_wait && en && pf) begin
                    n_wait = 1'b0;
                    n_go   = 1'b1;
                end
                if (acc) begin
                    exp_q.push_back('{m_filled, s_data});
                    n_filled = m_filled + 1;
                    if (n_filled == TAPS) begin
                        if (pf) n_go = 1'b1;
                        else    n_wait = 1'b1;
                    end
                end
                m_active = m_active || en;
                m_load   = acc;
                m_swap   = n_swap;
                m_fv     = n_fv;
                m_go     = n_go;
                m_wait   = n_wait;
                m_filled = n_filled;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one sample until accepted, bounded by a cycle budget.
    task automatic send(input logic [DW-1:0] d);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic send_frame();
        for (int i = 0; i < TAPS; i++) send(DW'($urandom));
    endtask

    logic [DW-1:0] vec [8] = '{9'h1A4, 9'h0E6, 9'h139, 9'h0CE, 9'h0F1, 9'h19E, 9'h13C, 9'h1C6};

    initial begin
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; f_ready = 1'b0; s_data = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        // 1: reset with random inputs
        repeat (3) begin
            en = 1'($urandom); s_valid = 1'($urandom); f_ready = 1'($urandom);
            s_data = DW'($urandom);
            tick(1);
        end
        @(negedge clk);
        chk("rst_dl_count", dl_count, 0);
        chk("rst_dl_data", dl_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_f_valid", f_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b1; f_ready = 1'b1; s_valid = 1'b0;

        // 2: directed frame back-to-back
        for (int i = 0; i < TAPS; i++) send(vec[i]);
        tick(6);

        // 3: two frames with downstream stalled, then release
        f_ready = 1'b0;
        send_frame();
        send_frame();
        tick(6);
        @(negedge clk);
        chk("hold_s_ready", s_ready, 0);
        chk("hold_f_valid", f_valid, 1);
        @(posedge clk);
        #1;
        f_ready = 1'b1;
        tick(8);

        // 4: enable dropped mid-frame
        for (int i = 0; i < 4; i++) send(DW'($urandom));
        en = 1'b0;
        tick(5);
        en = 1'b1;
        for (int i = 0; i < 4; i++) send(DW'($urandom));
        tick(6);

        // 5: reset mid-frame, next frame restarts at slot 0
        for (int i = 0; i < 5; i++) send(DW'($urandom));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send_frame();
        tick(6);

`ifdef DLYCTRL_FRAME_CNT_EN
        // 6: frame counter count and wrap
        send_frame();
        send_frame();
        tick(6);
        @(negedge clk);
        chk("frame_cnt_three", frame_cnt, 3);
        @(posedge clk);
        #1;
        force dut.r_frame_cnt = 16'hFFFF;
        m_frames = 16'hFFFF;
        tick(1);
        release dut.r_frame_cnt;
        send_frame();
        tick(6);
        @(negedge clk);
        chk("frame_cnt_wrap", frame_cnt, 0);
        @(posedge clk);
        #1;
`endif

        // Random traffic with occasional reset and enable drops
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            s_valid = 1'($urandom);
            f_ready = ($urandom_range(0, 2) != 0);
            s_data  = DW'($urandom);
            rst     = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0; en = 1'b1; f_ready = 1'b1; s_valid = 1'b0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
